bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It sits directly upstream of the per-digit seven-segment drivers. It takes an unsigned binary value and produces DIGITS packed BCD nibbles. Optional leading-zero blanking emits nibble 4'b1111, which the downstream drivers render as segments OFF. A start/busy/done handshake lets a counter or ALU feed it at its own rate.

---
 rtl/bin_to_bcd_seq_pkg.sv | 20 ++
 rtl/bin_to_bcd_seq_if.sv | 39 +++
 rtl/bin_to_bcd_seq_bcd_add3_adjust.sv | 17 +
 rtl/bin_to_bcd_seq.sv | 154 +++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   BCD_DIGIT_W  : width of one packed BCD digit
//   BLANK_NIBBLE : nibble code the seven-segment drivers render as "all off"
//   state_t      : converter FSM state encoding
// -----------------------------------------------------------------------------
package bin_to_bcd_seq_pkg;

    localparam int BCD_DIGIT_W = 4;

    localparam logic [BCD_DIGIT_W-1:0] BLANK_NIBBLE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq_if
// Request/result bundle between a value producer (counter, ALU) and the
// converter.
//   start     : request a conversion (only honoured while the converter idles)
//   binIn     : unsigned value to convert
//   zeroBlank : leading-zero blanking enable for this conversion
//   busy      : conversion in progress
//   done      : one-cycle pulse, digitsOut/ovf just updated
//   ovf       : last captured value did not fit in DIGITS decimal digits
//   digitsOut : packed BCD, digit 0 (ones) in the low nibble
// master = producer side, slave = converter side.
// -----------------------------------------------------------------------------
interface bin_to_bcd_seq_if
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) ();

    logic                          start;
    logic [WIDTH-1:0]              binIn;
    logic                          zeroBlank;
    logic                          busy;
    logic                          done;
    logic                          ovf;
    logic [BCD_DIGIT_W*DIGITS-1:0] digitsOut;

    modport master (
        output start, binIn, zeroBlank,
        input  busy, done, ovf, digitsOut
    );

    modport slave (
        input  start, binIn, zeroBlank,
        output busy, done, ovf, digitsOut
    );

endinterface

// File: rtl/bin_to_bcd_seq_bcd_add3_adjust.sv
// -----------------------------------------------------------------------------
// bcd_add3_adjust
// Double-dabble correction for one BCD digit: digits of 5 or more get 3 added
// so that the following left shift carries correctly into the next decade.
//   din  : accumulator digit before the shift
//   dout : corrected digit
// -----------------------------------------------------------------------------
module bcd_add3_adjust
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3) feeding per-digit
// seven-segment drivers. One bit is consumed per clock; a conversion takes
// WIDTH+2 cycles from accepted start to the next possible start.
//   clk  : rising-edge clock
//   rstN : asynchronous active-low reset
//   bus  : bin_to_bcd_seq_if slave (start/binIn/zeroBlank in,
//          busy/done/ovf/digitsOut out)
// digitsOut and ovf only change on the done cycle, so the display never shows
// partial results.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic            clk,
    input  logic            rstN,
    bin_to_bcd_seq_if.slave bus
);

    localparam int ACC_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(10**DIGITS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_adj;
    logic [CNT_W-1:0] cnt_q;
    logic             blank_q;
    logic             ovf_cap_q;

    logic             busy_q;
    logic             done_q;
    logic             ovf_q;
    logic [ACC_W-1:0] digits_q;

    logic             load;
    logic             shift_en;
    logic             finish;
    logic             lead;
    logic [ACC_W-1:0] final_digits;

    // Per-digit correction applied before every shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3_adjust u_adj (
            .din  (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Next-state and step strobes.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift_en = 1'b0;
        finish   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                // Counter runs WIDTH..1; the shift taken at 1 is the last one.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                finish  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Leading-zero blanking scans from the top digit down and stops at the
    // first non-zero digit; digit 0 is always shown. Overflow blanks all.
    always_comb begin
        final_digits = acc_q;
        lead         = blank_q;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && (acc_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0)) begin
                final_digits[i*BCD_DIGIT_W +: BCD_DIGIT_W] = BLANK_NIBBLE;
            end else begin
                lead = 1'b0;
            end
        end
        if (ovf_cap_q) begin
            final_digits = {DIGITS{BLANK_NIBBLE}};
        end
    end

    // ---- conversion datapath: capture, then one adjust+shift per cycle ----
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sr_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            blank_q   <= 1'b0;
            ovf_cap_q <= 1'b0;
        end else if (load) begin
            sr_q      <= bus.binIn;
            acc_q     <= '0;
            cnt_q     <= CNT_W'(WIDTH);
            blank_q   <= bus.zeroBlank;
            ovf_cap_q <= (bus.binIn > MAX_VAL);
        end else if (shift_en) begin
            {acc_q, sr_q} <= {acc_adj[ACC_W-2:0], sr_q, 1'b0};
            cnt_q         <= cnt_q - CNT_W'(1);
        end
    end

    // ---- result stage: outputs only move on the finish cycle ----
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            digits_q <= {DIGITS{BLANK_NIBBLE}};
        end else begin
            done_q <= finish;
            if (load) begin
                busy_q <= 1'b1;
            end else if (finish) begin
                busy_q <= 1'b0;
            end
            if (finish) begin
                digits_q <= final_digits;
                ovf_q    <= ovf_cap_q;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ovf       = ovf_q;
    assign bus.digitsOut = digits_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Directed bench for bin_to_bcd_seq (WIDTH=14, DIGITS=4): a vector table of
// values with hand-computed BCD results, plus sequences for held start,
// start-in-done-cycle and reset during a conversion.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    localparam int WIDTH  = 14;
    localparam int DIGITS = 4;

    logic clk;
    logic rstN;

    bin_to_bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] bin;
        logic        zb;
        logic [15:0] exp_digits;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[12];

    int          checks;
    int          errors;
    logic [15:0] prev_digits;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Full conversion: start pulse, latency, held outputs, result, done width.
    task automatic do_conv(input logic [13:0] v, input logic zb,
                           input logic [15:0] exp_d, input logic exp_o,
                           input string name);
        int   n;
        logic held_ok;
        logic got_done;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.binIn     = v;
        bus.zeroBlank = zb;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.binIn = ~v;           // later changes must not matter
        check({name, " busy_after_start"}, 32'(bus.busy), 32'd1);
        n        = 0;
        held_ok  = 1'b1;
        got_done = 1'b0;
        while (n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (bus.done) begin
                got_done = 1'b1;
                break;
            end
            if (bus.digitsOut !== prev_digits) held_ok = 1'b0;
        end
        if (!got_done) begin
            errors++;
            checks++;
            $display("FAIL %s timeout: no done within 40 cycles", name);
        end else begin
            check({name, " latency"}, 32'(n), 32'd15);
            check({name, " digits_held"}, 32'(held_ok), 32'd1);
            check({name, " digits"}, 32'(bus.digitsOut), 32'(exp_d));
            check({name, " ovf"}, 32'(bus.ovf), 32'(exp_o));
            check({name, " busy_at_done"}, 32'(bus.busy), 32'd0);
            @(posedge clk);
            @(negedge clk);
            check({name, " done_one_cycle"}, 32'(bus.done), 32'd0);
        end
        prev_digits = exp_d;
    endtask

    initial begin
        int          dones;
        logic [13:0] v;
        checks = 0;
        errors = 0;

        vecs[0]  = '{14'd1234,  1'b0, 16'h1234, 1'b0};
        vecs[1]  = '{14'd42,    1'b1, 16'hFF42, 1'b0};
        vecs[2]  = '{14'd42,    1'b0, 16'h0042, 1'b0};
        vecs[3]  = '{14'd0,     1'b1, 16'hFFF0, 1'b0};
        vecs[4]  = '{14'd9999,  1'b0, 16'h9999, 1'b0};
        vecs[5]  = '{14'd10000, 1'b0, 16'hFFFF, 1'b1};
        vecs[6]  = '{14'd0,     1'b0, 16'h0000, 1'b0};
        vecs[7]  = '{14'd7,     1'b1, 16'hFFF7, 1'b0};
        vecs[8]  = '{14'd1005,  1'b1, 16'h1005, 1'b0};
        vecs[9]  = '{14'd100,   1'b1, 16'hF100, 1'b0};
        vecs[10] = '{14'd16383, 1'b1, 16'hFFFF, 1'b1};
        vecs[11] = '{14'd5,     1'b0, 16'h0005, 1'b0};

        rstN          = 1'b0;
        bus.start     = 1'b0;
        bus.binIn     = '0;
        bus.zeroBlank = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        repeat (5) @(negedge clk);
        check("reset digitsOut", 32'(bus.digitsOut), 32'hFFFF);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset ovf", 32'(bus.ovf), 32'd0);
        prev_digits = 16'hFFFF;

        for (int i = 0; i < 12; i++) begin
            do_conv(vecs[i].bin, vecs[i].zb, vecs[i].exp_digits, vecs[i].exp_ovf,
                    $sformatf("vec%0d", i));
        end

        // Start held high, binIn = 1000 + 111*c changing every cycle: only the
        // values present at edges 0, 16 and 32 are accepted.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.zeroBlank = 1'b0;
        bus.binIn     = 14'd1000;
        dones         = 0;
        for (int c = 0; c < 48; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) dones++;
            if (c == 15) begin
                check("held_start done1", 32'(bus.done), 32'd1);
                check("held_start digits1", 32'(bus.digitsOut), 32'h1000);
            end
            if (c == 31) begin
                check("held_start done2", 32'(bus.done), 32'd1);
                check("held_start digits2", 32'(bus.digitsOut), 32'h2776);
            end
            if (c == 47) begin
                check("held_start done3", 32'(bus.done), 32'd1);
                check("held_start digits3", 32'(bus.digitsOut), 32'h4552);
            end
            if (c >= 32) begin
                bus.start = 1'b0;
            end else begin
                v         = 14'(1000 + 111 * (c + 1));
                bus.binIn = v;
            end
        end
        check("held_start done_count", 32'(dones), 32'd3);
        prev_digits = 16'h4552;

        // Reset pulled 7 cycles into a conversion of 5678.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.binIn     = 14'd5678;
        bus.zeroBlank = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        check("midreset digitsOut", 32'(bus.digitsOut), 32'hFFFF);
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset done", 32'(bus.done), 32'd0);
        check("midreset ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        prev_digits = 16'hFFFF;
        do_conv(14'd321, 1'b1, 16'hF321, 1'b0, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
